// File: rtl/tgl_pkg.sv
// Shared types and helpers for the toggle-handshake receiver.
package tgl_pkg;

  typedef enum logic {IDLE, PEND} state_e;

  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/tgl_sync.sv
// Multi-flop synchroniser for the asynchronous request toggle.
module tgl_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_pulse_rx.sv
// Receive side of a two-phase toggle handshake: one valid/ready event per req_t change.
// Optional macro TGL_RX_TIMEOUT_EN retires events the consumer does not accept in TIMEOUT cycles.
module toggle_pulse_rx
  import tgl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_t,
  output logic             ack_t,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             ovf_err,
  output logic             tmo_err,
  input  logic             clr_err
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || CNT_W < 1 || CNT_W > 32 || TIMEOUT < 1) begin : g_bad_param
    $error("toggle_pulse_rx: illegal parameter value");
  end

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic       req_s;
  logic       req_d_q;
  logic       req_edge;
  state_e     state_q, state_d;
  logic       ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;

  tgl_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (req_t),
    .q    (req_s)
  );

  assign req_edge = req_s ^ req_d_q;

`ifdef TGL_RX_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             tmo_q, tmo_d;
  logic             tmo_hit;

  // Counts cycles spent in PEND; restarts from zero on every entry.
  assign wait_d  = (state_q == PEND) ? wait_q + 1'b1 : '0;
  assign tmo_hit = (wait_q == WaitW'(TIMEOUT - 1));
  assign tmo_err = tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      tmo_q  <= tmo_d;
    end
  end
`else
  assign tmo_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    // Clear first so a same-cycle error still sets the flag.
    ovf_d   = ovf_q & ~clr_err;
`ifdef TGL_RX_TIMEOUT_EN
    tmo_d   = tmo_q & ~clr_err;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_edge) state_d = PEND;
      end
      PEND: begin
        if (req_edge) ovf_d = 1'b1;
        if (evt_ready) begin
          state_d = IDLE;
          ack_d   = ~ack_q;
          cnt_d   = CNT_W'(sat_inc(32'(cnt_q), 32'(CntMax)));
        end
`ifdef TGL_RX_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = IDLE;
          ack_d   = ~ack_q;
          tmo_d   = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d_q <= 1'b0;
      state_q <= IDLE;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      req_d_q <= req_s;
      state_q <= state_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid = (state_q == PEND);
  assign ack_t     = ack_q;
  assign evt_cnt   = cnt_q;
  assign ovf_err   = ovf_q;

endmodule
